// File: rtl/ofdm_tx_pkg.sv
// Shared types and default sizing for the OFDM transmit datapath.
// Sample layout is {Q[31:16], I[15:0]}.
package ofdm_tx_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NFFT_DEF   = 1024;
  localparam int CP_MAX_DEF = 256;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] i;
  } iq_sample_t;

  typedef enum logic [1:0] {
    IDLE,
    CP,
    BODY
  } rd_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output buffer with a registered head slot.
// It gives the upstream RAM read one cycle of slack under backpressure.
module axis_skid_buf
  import ofdm_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              can_issue,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  logic [DATA_W:0] slot0;
  logic [DATA_W:0] slot1;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic [1:0]      occ_next;

  assign push    = s_valid;
  assign pop     = m_valid & m_ready;
  assign m_valid = (count != 2'd0);
  assign m_data  = slot0[DATA_W-1:0];
  assign m_last  = slot0[DATA_W] & m_valid;

  // An issue now lands here next cycle, so leave room for it.
  assign occ_next  = count + {1'b0, push} - {1'b0, pop};
  assign can_issue = (occ_next != 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= {s_last, s_data};
          else               slot1 <= {s_last, s_data};
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= {s_last, s_data};
          end else begin
            slot0 <= slot1;
            slot1 <= {s_last, s_data};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ofdm_cp_inserter.sv
// Ping-pong symbol buffer that replays the last cp_len samples ahead of each IFFT symbol.
//   state | meaning
//   IDLE  | waiting for the read bank to fill; issues its first read as soon as it does
//   CP    | reading the prefix, addresses NFFT-cpl .. NFFT-1
//   BODY  | reading the full symbol, addresses 0 .. NFFT-1
module ofdm_cp_inserter
  import ofdm_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NFFT   = NFFT_DEF,
  parameter int CP_MAX = CP_MAX_DEF,
  localparam int AW    = $clog2(NFFT),
  localparam int CW    = $clog2(CP_MAX + 1)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [CW-1:0]     cp_len,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              err_tlast,
  output logic [15:0]       sym_count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);

  logic [DATA_W-1:0] mem [2*NFFT];

  logic          rst_done;
  logic          wr_bank;
  logic [AW-1:0] wr_idx;
  logic          wr_fire;
  logic [1:0]    full;
  logic [1:0]    tl_flag;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  rd_state_e     state;
  rd_state_e     cur_st;
  rd_state_e     start_st;
  logic          rd_bank;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] cur_idx;
  logic [AW-1:0] start_idx;
  logic [CW-1:0] cpl_now;
  logic          active;
  logic          rd_en;
  logic          last_body;
  logic          can_issue;

  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic              rd_last;

  assign s_tready = rst_done & ~full[wr_bank];
  assign wr_fire  = s_tvalid & s_tready;

  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (wr_fire && wr_idx == LAST_IDX) full_set[wr_bank] = 1'b1;
    if (rd_en && last_body)            full_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rst_done  <= 1'b0;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      full      <= 2'b00;
      tl_flag   <= 2'b00;
      err_tlast <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      full     <= (full | full_set) & ~full_clr;
      if (wr_fire) begin
        if (wr_idx == LAST_IDX) begin
          tl_flag[wr_bank] <= s_tlast;
          wr_bank          <= ~wr_bank;
          wr_idx           <= '0;
        end else begin
          wr_idx <= wr_idx + AW'(1);
          if (s_tlast) err_tlast <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_fire) mem[{wr_bank, wr_idx}] <= s_tdata;
  end

  // Where a new symbol starts: CP at NFFT-cpl, or straight into BODY when there is no prefix.
  always_comb begin
    cpl_now   = (cp_len > CW'(CP_MAX)) ? CW'(CP_MAX) : cp_len;
    start_st  = (cpl_now == '0) ? BODY : CP;
    start_idx = (cpl_now == '0) ? '0 : AW'(NFFT - int'(cpl_now));
    cur_st    = state;
    cur_idx   = rd_idx;
    active    = 1'b1;
    if (state == IDLE) begin
      cur_st  = start_st;
      cur_idx = start_idx;
      active  = full[rd_bank];
    end
    rd_en     = active & can_issue;
    last_body = (cur_st == BODY) && (cur_idx == LAST_IDX);
  end

  always_ff @(posedge aclk) begin
    if (rd_en) rd_data <= mem[{rd_bank, cur_idx}];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      sym_count <= 16'd0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      rd_vld  <= rd_en;
      rd_last <= rd_en & last_body & tl_flag[rd_bank];
      if (rd_en) begin
        if (cur_st == CP) begin
          if (cur_idx == LAST_IDX) begin
            state  <= BODY;
            rd_idx <= '0;
          end else begin
            state  <= CP;
            rd_idx <= cur_idx + AW'(1);
          end
        end else if (cur_idx == LAST_IDX) begin
          rd_bank   <= ~rd_bank;
          sym_count <= sym_count + 16'd1;
          if (full[~rd_bank]) begin
            state  <= start_st;
            rd_idx <= start_idx;
          end else begin
            state  <= IDLE;
            rd_idx <= '0;
          end
        end else begin
          state  <= BODY;
          rd_idx <= cur_idx + AW'(1);
        end
      end
    end
  end

  axis_skid_buf #(.DATA_W(DATA_W)) u_out (
    .clk       (aclk),
    .rst       (areset),
    .s_valid   (rd_vld),
    .s_data    (rd_data),
    .s_last    (rd_last),
    .can_issue (can_issue),
    .m_data    (m_tdata),
    .m_valid   (m_tvalid),
    .m_last    (m_tlast),
    .m_ready   (m_tready)
  );

endmodule
